// File: rtl/gather_sequencer_if.sv
// Mesh PE port bundle between the gather sequencer (master) and the 4x4 mesh (slave).
// Packets are 64 bits per node, node i occupying bits [64*i+63:64*i].
interface gather_sequencer_if;
    logic [15:0]   pesi;   // per-node inject valid
    logic [1023:0] pedi;   // per-node inject packet
    logic [15:0]   peri;   // per-node inject ready
    logic [15:0]   pero;   // per-node eject enable
    logic [15:0]   peso;   // per-node eject valid
    logic [1023:0] pedo;   // per-node ejected packet

    modport master (output pesi, pedi, pero, input peri, peso, pedo);
    modport slave  (input pesi, pedi, pero, output peri, peso, pedo);
endinterface

// File: rtl/gather_sequencer.sv
// Gather-traffic sequencer for the 4x4 mesh: in phase p every node except p
// injects one packet to node p, node p's ejection port collects them, and the
// phase closes once all 15 sources have been seen or the phase timer expires.
// Optional feature macro: GATHER_CHECK_EN enables per-packet decode and the
// saturating error counter; without it err_cnt is tied to zero.
module gather_sequencer #(
    parameter int TIMEOUT_CYC = 1023,
    parameter int GAP_CYC     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    gather_sequencer_if.master mesh,
    output logic               o_busy,
    output logic               o_done,
    output logic [3:0]         o_phase,
    output logic [7:0]         o_err_cnt,
    output logic               o_timeout
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INJECT = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    // Packet a source node sends towards the current destination.
    function automatic logic [63:0] f_pkt(input logic [3:0] src, input logic [3:0] dst);
        logic [1:0]  sx, sy, dx, dy, hx, hy, dir;
        logic [31:0] pay;
        sx  = src[1:0];
        sy  = src[3:2];
        dx  = dst[1:0];
        dy  = dst[3:2];
        dir = {dx > sx, dy > sy};
        hx  = (dx > sx) ? dx - sx : sx - dx;
        hy  = (dy > sy) ? dy - sy : sy - dy;
        pay = 32'h1111_1111 * {28'd0, src};
        return {1'b0, dir, 5'b0, {2'b0, hx}, {2'b0, hy}, {6'b0, sx}, {6'b0, sy}, pay};
    endfunction

    logic [2:0]       r_state;
    logic [3:0]       r_phase;
    logic [15:0]      r_pend;
    logic [15:0]      r_seen;
    logic [TMR_W-1:0] r_tmr;
    logic [GAP_W-1:0] r_gap;
    logic             r_timeout;

    logic             w_active;
    logic [15:0]      w_target;
    logic [15:0]      w_next_target;
    logic [63:0]      w_pkt;
    logic             w_rx;
    logic             w_src_ok;
    logic [3:0]       w_s;
    logic [15:0]      w_seen_nx;
    logic [15:0]      w_pesi;
    logic [15:0]      w_pend_nx;
    logic             w_all_seen;
    logic             w_tmo;
    logic             w_gap_end;
    logic             w_unused_pkt;

    // Receive decode, completion tracking and inject bookkeeping for this cycle.
    always_comb begin
        w_active      = (r_state == S_INJECT) || (r_state == S_DRAIN);
        w_target      = ~(16'd1 << r_phase);
        w_next_target = ~(16'd1 << (r_phase + 4'd1));
        w_pkt         = mesh.pedo[{r_phase, 6'b0} +: 64];
        w_rx          = w_active && mesh.peso[r_phase];
        // Source coordinates beyond the 4x4 grid cannot name a node.
        w_src_ok      = (w_pkt[47:42] == 6'd0) && (w_pkt[39:34] == 6'd0);
        w_s           = {w_pkt[33:32], w_pkt[41:40]};
        w_seen_nx     = r_seen;
        if (w_rx && w_src_ok) begin
            // The destination itself is never a valid source, so mask it out.
            w_seen_nx = r_seen | ((16'd1 << w_s) & w_target);
        end
        w_pesi        = (r_state == S_INJECT) ? r_pend : 16'd0;
        w_pend_nx     = r_pend & ~(w_pesi & mesh.peri);
        w_all_seen    = (w_seen_nx == w_target);
        w_tmo         = (r_tmr == TMR_LAST);
        w_gap_end     = (r_gap == GAP_LAST);
    end

    assign w_unused_pkt = &{1'b0, w_pkt};

    // Drive the mesh ports: inject valids/packets and the one-hot eject enable.
    always_comb begin
        mesh.pesi = w_pesi;
        mesh.pero = w_active ? (16'd1 << r_phase) : 16'd0;
        for (int i = 0; i < 16; i++) begin
            mesh.pedi[64*i +: 64] = w_active ? f_pkt(4'(i), r_phase) : 64'd0;
        end
    end

    // Phase sequencing FSM with per-phase timer and inter-phase gap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_phase   <= 4'd0;
            r_pend    <= 16'd0;
            r_seen    <= 16'd0;
            r_tmr     <= '0;
            r_gap     <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state   <= S_INJECT;
                        r_phase   <= 4'd0;
                        r_pend    <= 16'hFFFE;
                        r_seen    <= 16'd0;
                        r_tmr     <= '0;
                        r_timeout <= 1'b0;
                    end
                end
                S_INJECT: begin
                    r_pend <= w_pend_nx;
                    r_seen <= w_seen_nx;
                    r_tmr  <= r_tmr + TMR_W'(1);
                    if (w_pend_nx == 16'd0 && w_all_seen) begin
                        r_state <= S_GAP;
                        r_gap   <= '0;
                    end else if (w_tmo) begin
                        r_state   <= S_GAP;
                        r_gap     <= '0;
                        r_timeout <= 1'b1;
                    end else if (w_pend_nx == 16'd0) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_seen <= w_seen_nx;
                    r_tmr  <= r_tmr + TMR_W'(1);
                    if (w_all_seen) begin
                        r_state <= S_GAP;
                        r_gap   <= '0;
                    end else if (w_tmo) begin
                        r_state   <= S_GAP;
                        r_gap     <= '0;
                        r_timeout <= 1'b1;
                    end
                end
                S_GAP: begin
                    r_gap <= r_gap + GAP_W'(1);
                    if (w_gap_end) begin
                        if (r_phase == 4'd15) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_INJECT;
                            r_phase <= r_phase + 4'd1;
                            r_pend  <= w_next_target;
                            r_seen  <= 16'd0;
                            r_tmr   <= '0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef GATHER_CHECK_EN
    // Route the packet back to its destination and compare against the phase.
    function automatic logic f_bad(input logic [63:0] pkt, input logic [3:0] s,
                                   input logic [3:0] ph, input logic dup);
        logic [7:0] des_x, des_y, des_idx;
        des_x   = pkt[62] ? pkt[47:40] + {4'b0, pkt[55:52]} : pkt[47:40] - {4'b0, pkt[55:52]};
        des_y   = pkt[61] ? pkt[39:32] + {4'b0, pkt[51:48]} : pkt[39:32] - {4'b0, pkt[51:48]};
        des_idx = {des_y[5:0], 2'b00} + des_x;
        return (des_idx != {4'b0, ph}) || (pkt[31:0] != 32'h1111_1111 * {28'd0, s}) ||
               (s == ph) || dup;
    endfunction

    logic [7:0] r_err_cnt;
    logic       w_err;

    // A received packet is an error if its source is off-grid or any field disagrees.
    always_comb begin
        w_err = w_rx && (!w_src_ok || f_bad(w_pkt, w_s, r_phase, r_seen[w_s]));
    end

    // Saturating error counter, cleared at the start of each run.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err_cnt <= 8'd0;
        end else if (i_start && (r_state == S_IDLE || r_state == S_DONE)) begin
            r_err_cnt <= 8'd0;
        end else if (w_err && r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign o_err_cnt = r_err_cnt;
`else
    assign o_err_cnt = 8'd0;
`endif

    assign o_busy    = (r_state == S_INJECT) || (r_state == S_DRAIN) || (r_state == S_GAP);
    assign o_done    = (r_state == S_DONE);
    assign o_phase   = r_phase;
    assign o_timeout = r_timeout;
endmodule

// File: tb/tb_gather_sequencer.sv
// Bench for gather_sequencer: an ideal mesh model echoes every accepted packet
// to its destination five cycles later (one ejection per cycle), with knobs to
// stall, drop, corrupt or duplicate individual packets.
module tb_gather_sequencer;
    localparam int TIMEOUT_CYC = 1023;
    localparam int GAP_CYC     = 4;
`ifdef GATHER_CHECK_EN
    localparam int EXP_ERR = 1;
`else
    localparam int EXP_ERR = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy, done, timeout;
    logic [3:0] phase;
    logic [7:0] err_cnt;

    gather_sequencer_if ifc();

    gather_sequencer #(.TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_start   (start),
        .mesh      (ifc),
        .o_busy    (busy),
        .o_done    (done),
        .o_phase   (phase),
        .o_err_cnt (err_cnt),
        .o_timeout (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference packet from node i to destination p, straight from the packet format.
    function automatic logic [63:0] exp_pkt(input int i, input int p);
        int sx, sy, px, py, hx, hy;
        logic [1:0]  dir;
        logic [31:0] pay;
        sx = i % 4; sy = i / 4; px = p % 4; py = p / 4;
        dir[1] = (px > sx);
        dir[0] = (py > sy);
        hx = (px > sx) ? px - sx : sx - px;
        hy = (py > sy) ? py - sy : sy - py;
        pay = 32'h1111_1111 * i;
        return {1'b0, dir, 5'b0, hx[3:0], hy[3:0], sx[7:0], sy[7:0], pay};
    endfunction

    typedef struct {
        int          due;
        logic [3:0]  dst;
        logic [63:0] data;
    } pkt_t;

    pkt_t        q[$];
    logic        stall_req  = 1'b0;
    logic        drop_en    = 1'b0;
    logic        corrupt_en = 1'b0;
    logic        dup_en     = 1'b0;
    int          acc_cnt[16];
    int          stall_left = 0;
    int          held_cyc   = 0;
    int          pedi_bad   = 0;
    int          proto_bad  = 0;
    int          ph2_len    = 0;
    logic [63:0] cap_n0     = 64'd0;
    logic [63:0] cap_n3     = 64'd0;
    logic        cap_done   = 1'b0;

    // Mesh model: observe on the falling edge, present ejections just after the rising edge.
    initial begin : mesh_model
        pkt_t pk;
        ifc.peri = '1;
        ifc.peso = '0;
        ifc.pedo = '0;
        forever begin
            @(negedge clk);
            if (!reset) q.delete();
            if (start && !busy) begin
                for (int k = 0; k < 16; k++) acc_cnt[k] = 0;
                held_cyc   = 0;
                pedi_bad   = 0;
                proto_bad  = 0;
                ph2_len    = 0;
                cap_done   = 1'b0;
                stall_left = stall_req ? 20 : 0;
            end
            if (ifc.pesi[phase]) proto_bad++;
            if (ifc.pesi != 16'd0 && ifc.pero != (16'd1 << phase)) proto_bad++;
            if (ifc.pero != 16'd0 && ifc.pero != (16'd1 << phase)) proto_bad++;
            if (phase == 4'd2 && ifc.pero != 16'd0) ph2_len++;
            if (!cap_done && phase == 4'd10 && ifc.pesi != 16'd0) begin
                cap_n0   = ifc.pedi[63:0];
                cap_n3   = ifc.pedi[255:192];
                cap_done = 1'b1;
            end
            for (int i = 0; i < 16; i++) begin
                if (ifc.pesi[i]) begin
                    if (ifc.pedi[64*i +: 64] !== exp_pkt(i, int'(phase))) pedi_bad++;
                    if (!ifc.peri[i]) begin
                        if (i == 1) held_cyc++;
                    end else begin
                        acc_cnt[phase]++;
                        pk.due  = cyc + 5;
                        pk.dst  = phase;
                        pk.data = ifc.pedi[64*i +: 64];
                        if (corrupt_en && i == 5 && phase == 4'd0) pk.data[31:0] = 32'h0;
                        if (!(drop_en && i == 7 && phase == 4'd2)) q.push_back(pk);
                        if (dup_en && i == 5 && phase == 4'd0) q.push_back(pk);
                    end
                end
            end
            @(posedge clk);
            #1;
            ifc.peso = '0;
            ifc.pedo = '0;
            ifc.peri = '1;
            if (stall_left > 0 && ifc.pesi[1]) begin
                ifc.peri[1] = 1'b0;
                stall_left--;
            end
            if (q.size() > 0 && q[0].due <= cyc) begin
                ifc.peso[q[0].dst] = 1'b1;
                ifc.pedo[64*int'(q[0].dst) +: 64] = q[0].data;
                void'(q.pop_front());
            end
        end
    end

    function automatic int full_phases();
        int n = 0;
        for (int k = 0; k < 16; k++) if (acc_cnt[k] == 15) n++;
        return n;
    endfunction

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk_eq(tag, done, 1);
    endtask

    task automatic wait_inject(input string tag, input logic [3:0] ph, input int limit);
        int n = 0;
        while (!(busy && phase == ph && ifc.pesi != 16'd0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk_eq(tag, (n < limit), 1);
    endtask

    task automatic check_zero(input string pfx);
        chk_eq({pfx, "_pesi"}, ifc.pesi, 0);
        chk_eq({pfx, "_pedi"}, {63'd0, |ifc.pedi}, 0);
        chk_eq({pfx, "_pero"}, ifc.pero, 0);
        chk_eq({pfx, "_busy"}, busy, 0);
        chk_eq({pfx, "_done"}, done, 0);
        chk_eq({pfx, "_phase"}, phase, 0);
        chk_eq({pfx, "_err"}, err_cnt, 0);
        chk_eq({pfx, "_tmo"}, timeout, 0);
    endtask

    task automatic end_status(input string pfx, input int exp_err, input int exp_tmo);
        chk_eq({pfx, "_busy"}, busy, 0);
        chk_eq({pfx, "_phase"}, phase, 15);
        chk_eq({pfx, "_err"}, err_cnt, exp_err);
        chk_eq({pfx, "_tmo"}, timeout, exp_tmo);
        chk_eq({pfx, "_acc"}, full_phases(), 16);
        chk_eq({pfx, "_pedi"}, pedi_bad, 0);
        chk_eq({pfx, "_proto"}, proto_bad, 0);
    endtask

    initial begin : watchdog
        repeat (30000) @(posedge clk);
        $display("FAIL watchdog: got %0d cycles, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_zero("rst");
        reset = 1'b1;

        // Run 1: ideal mesh, node 1 stalled for 20 cycles in phase 0, start ignored in phase 3.
        stall_req = 1'b1;
        pulse_start();
        stall_req = 1'b0;
        chk_eq("r1_busy", busy, 1);
        chk_eq("r1_phase0", phase, 0);
        wait_inject("r1_reach3", 4'd3, 1000);
        pulse_start();
        chk_eq("r1_ign_phase", phase, 3);
        chk_eq("r1_ign_busy", busy, 1);
        wait_done("r1_done", 2000);
        end_status("r1", 0, 0);
        chk_eq("r1_held", held_cyc, 20);
        // Node 10 is (2,2): node 0 lies west/north on both axes, node 3 lies east of it.
        chk_eq("r1_p10_n0", cap_n0, 64'h6022_0000_0000_0000);
        chk_eq("r1_p10_n3", cap_n3, 64'h2012_0300_3333_3333);

        // Run 2: node 7's packet lost in phase 2.
        drop_en = 1'b1;
        pulse_start();
        chk_eq("r2_phase0", phase, 0);
        wait_done("r2_done", 4000);
        drop_en = 1'b0;
        end_status("r2", 0, 1);
        chk_eq("r2_ph2_len", ph2_len, TIMEOUT_CYC);

        // Run 3: node 5's payload zeroed in phase 0; timeout from run 2 must clear on start.
        corrupt_en = 1'b1;
        pulse_start();
        chk_eq("r3_tmo_clr", timeout, 0);
        wait_done("r3_done", 2000);
        corrupt_en = 1'b0;
        end_status("r3", EXP_ERR, 0);

        // Run 4: node 5's packet delivered twice in phase 0.
        dup_en = 1'b1;
        pulse_start();
        chk_eq("r4_err_clr", err_cnt, 0);
        wait_done("r4_done", 2000);
        dup_en = 1'b0;
        end_status("r4", EXP_ERR, 0);

        // Run 5: timeout in phase 2, then reset while phase 6 is injecting.
        drop_en = 1'b1;
        pulse_start();
        wait_inject("r5_reach6", 4'd6, 3000);
        chk_eq("r5_tmo_set", timeout, 1);
        reset = 1'b0;
        @(posedge clk);
        #1 check_zero("r5_rst");
        drop_en = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_eq("r5_idle_busy", busy, 0);
        chk_eq("r5_idle_done", done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
